uart_rx_ctrl: RTL and testbench

Receive-side controller for the APB UART: buffers characters pushed by the receiver FSM in a show-ahead FIFO, drives the receiver's FIFO-full input and the modem `rts_n` line with hysteresis, and raises threshold, character-timeout and overrun status toward the APB register block. It sits between `receiver` (write side) and the APB register file (read side).

---
 rtl/uart_rx_ctrl.sv | 169 ++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ctrl.sv
// Receive-side controller for the APB UART: show-ahead RX FIFO, rts_n hysteresis,
// threshold/overrun status, and character timeout (built only with UART_RX_TIMEOUT_EN).
module uart_rx_ctrl #(
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned FIFO_DEPTH    = 16,
    parameter int unsigned RTS_MARGIN    = 2,
    parameter int unsigned TIMEOUT_CHARS = 4,
    localparam int unsigned LVL_W        = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clken,
    input  logic                  rx_en,
    input  logic                  fifo_flush,
    input  logic                  rx_wr_req,
    input  logic [DATA_WIDTH-1:0] rx_data_in,
    input  logic                  rd_req,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [LVL_W-1:0]      rx_level,
    output logic                  rx_empty,
    output logic                  rx_full,
    input  logic [LVL_W-1:0]      thr,
    output logic                  irq_thr,
    output logic                  irq_tout,
    output logic                  ovr,
    input  logic                  ovr_clr,
    output logic                  rts_n
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);
    localparam logic [LVL_W-1:0] LVL_RTS_HI = LVL_W'(FIFO_DEPTH - RTS_MARGIN);
    localparam logic [LVL_W-1:0] LVL_RTS_LO = LVL_W'(FIFO_DEPTH / 2);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;

    logic                  do_push;
    logic                  do_pop;
    logic                  ovr_set;
    logic [LVL_W-1:0]      level_n;
    logic [PTR_W-1:0]      rd_ptr_n;
    logic [DATA_WIDTH-1:0] head_n;

    // Accept/drop decisions and next-state of level, read pointer and head register
    always_comb begin
        do_pop   = rd_req & ~rx_empty & ~fifo_flush;
        do_push  = rx_wr_req & rx_en & (~rx_full | (rd_req & ~rx_empty)) & ~fifo_flush;
        ovr_set  = rx_wr_req & rx_en & rx_full & ~rd_req & ~fifo_flush;
        level_n  = rx_level + LVL_W'(do_push) - LVL_W'(do_pop);
        rd_ptr_n = rd_ptr + PTR_W'(do_pop);
        head_n   = rd_data;
        if (fifo_flush) begin
            level_n  = '0;
            rd_ptr_n = '0;
        end else if (do_push && (rd_ptr_n == wr_ptr)) begin
            head_n = rx_data_in;
        end else if (level_n != '0) begin
            head_n = mem[rd_ptr_n];
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= rx_data_in;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            rx_level <= '0;
            rx_empty <= 1'b1;
            rx_full  <= 1'b0;
            rd_data  <= '0;
            irq_thr  <= 1'b0;
            rts_n    <= 1'b0;
            ovr      <= 1'b0;
        end else begin
            wr_ptr   <= fifo_flush ? '0 : wr_ptr + PTR_W'(do_push);
            rd_ptr   <= rd_ptr_n;
            rx_level <= level_n;
            rx_empty <= (level_n == '0);
            rx_full  <= (level_n == LVL_FULL);
            rd_data  <= head_n;
            irq_thr  <= (thr != '0) && (rx_level >= thr);
            // Hysteresis: between the two marks rts_n keeps its last value
            if (rx_level >= LVL_RTS_HI) begin
                rts_n <= 1'b1;
            end else if (rx_level <= LVL_RTS_LO) begin
                rts_n <= 1'b0;
            end
            if (ovr_set) begin
                ovr <= 1'b1;
            end else if (ovr_clr) begin
                ovr <= 1'b0;
            end
        end
    end

`ifdef UART_RX_TIMEOUT_EN
    typedef enum logic [1:0] {T_IDLE, T_ARMED, T_EXPIRED} tout_state_t;

    localparam logic [15:0] TOUT_LAST = 16'(TIMEOUT_CHARS * 160 - 1);

    tout_state_t tstate;
    logic [15:0] tcnt;

    // Character timeout: counts clken ticks with no FIFO activity while data waits
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tstate   <= T_IDLE;
            tcnt     <= '0;
            irq_tout <= 1'b0;
        end else if (fifo_flush) begin
            tstate   <= T_IDLE;
            tcnt     <= '0;
            irq_tout <= 1'b0;
        end else begin
            irq_tout <= 1'b0;
            case (tstate)
                T_IDLE: begin
                    tcnt <= '0;
                    if (level_n != '0) begin
                        tstate <= T_ARMED;
                    end
                end
                T_ARMED: begin
                    if (level_n == '0) begin
                        tstate <= T_IDLE;
                        tcnt   <= '0;
                    end else if (do_push || do_pop) begin
                        tcnt <= '0;
                    end else if (clken) begin
                        if (tcnt == TOUT_LAST) begin
                            tstate   <= T_EXPIRED;
                            tcnt     <= '0;
                            irq_tout <= 1'b1;
                        end else begin
                            tcnt <= tcnt + 16'd1;
                        end
                    end
                end
                T_EXPIRED: begin
                    tcnt <= '0;
                    if (level_n == '0) begin
                        tstate <= T_IDLE;
                    end else if (do_push || do_pop) begin
                        tstate <= T_ARMED;
                    end else begin
                        irq_tout <= 1'b1;
                    end
                end
                default: begin
                    tstate <= T_IDLE;
                    tcnt   <= '0;
                end
            endcase
        end
    end
`else
    logic unused_tout;
    assign unused_tout = clken | (TIMEOUT_CHARS == 0);
    assign irq_tout    = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl; timeout checks adapt to UART_RX_TIMEOUT_EN.
module tb_uart_rx_ctrl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       clken;
    logic       rx_en;
    logic       fifo_flush;
    logic       rx_wr_req;
    logic [7:0] rx_data_in;
    logic       rd_req;
    logic [7:0] rd_data;
    logic [4:0] rx_level;
    logic       rx_empty;
    logic       rx_full;
    logic [4:0] thr;
    logic       irq_thr;
    logic       irq_tout;
    logic       ovr;
    logic       ovr_clr;
    logic       rts_n;

    int total = 0;
    int bad   = 0;

    uart_rx_ctrl dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .clken      (clken),
        .rx_en      (rx_en),
        .fifo_flush (fifo_flush),
        .rx_wr_req  (rx_wr_req),
        .rx_data_in (rx_data_in),
        .rd_req     (rd_req),
        .rd_data    (rd_data),
        .rx_level   (rx_level),
        .rx_empty   (rx_empty),
        .rx_full    (rx_full),
        .thr        (thr),
        .irq_thr    (irq_thr),
        .irq_tout   (irq_tout),
        .ovr        (ovr),
        .ovr_clr    (ovr_clr),
        .rts_n      (rts_n)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        rx_wr_req  = 1'b1;
        rx_data_in = d;
        tick();
        rx_wr_req  = 1'b0;
    endtask

    task automatic pop();
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
    endtask

    task automatic clken_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            clken = 1'b1;
            tick();
            clken = 1'b0;
            tick();
        end
    endtask

    initial begin
        reset_n    = 1'b0;
        clken      = 1'b0;
        rx_en      = 1'b1;
        fifo_flush = 1'b0;
        rx_wr_req  = 1'b0;
        rx_data_in = 8'h00;
        rd_req     = 1'b0;
        thr        = 5'd0;
        ovr_clr    = 1'b0;
        #12;
        check("rst_level", 32'(rx_level), 0);
        check("rst_empty", 32'(rx_empty), 1);
        check("rst_full",  32'(rx_full), 0);
        check("rst_data",  32'(rd_data), 0);
        check("rst_rts",   32'(rts_n), 0);
        check("rst_ovr",   32'(ovr), 0);
        check("rst_tout",  32'(irq_tout), 0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();

        // Basic FIFO order
        for (int i = 0; i < 4; i++) push(8'(8'h11 + i));
        check("b_level4", 32'(rx_level), 4);
        check("b_head",   32'(rd_data), 32'h11);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("b_rd%0d", i), 32'(rd_data), 32'(8'h11 + i));
            pop();
        end
        check("b_level0", 32'(rx_level), 0);
        check("b_empty",  32'(rx_empty), 1);
        pop();
        check("b_popempty_lvl",  32'(rx_level), 0);
        check("b_popempty_data", 32'(rd_data), 32'h14);

        // Fill with threshold, rts hysteresis and overrun
        thr = 5'd8;
        for (int k = 1; k <= 16; k++) begin
            push(8'(8'h20 + k - 1));
            tick();
            if (k == 7)  check("f_thr_lvl7",  32'(irq_thr), 0);
            if (k == 8)  check("f_thr_lvl8",  32'(irq_thr), 1);
            if (k == 13) check("f_rts_lvl13", 32'(rts_n), 0);
            if (k == 14) check("f_rts_lvl14", 32'(rts_n), 1);
        end
        check("f_full",  32'(rx_full), 1);
        check("f_level", 32'(rx_level), 16);
        push(8'hEE);
        check("f_ovr",      32'(ovr), 1);
        check("f_ovr_lvl",  32'(rx_level), 16);
        check("f_ovr_head", 32'(rd_data), 32'h20);
        for (int k = 1; k <= 8; k++) begin
            pop();
            tick();
            if (k == 7) check("f_rts_lvl9", 32'(rts_n), 1);
            if (k == 8) check("f_rts_lvl8", 32'(rts_n), 0);
        end
        check("f_head8",     32'(rd_data), 32'h28);
        check("f_ovr_stick", 32'(ovr), 1);
        ovr_clr = 1'b1;
        tick();
        ovr_clr = 1'b0;
        check("f_ovr_clr", 32'(ovr), 0);

        // Push+pop at full
        for (int i = 0; i < 8; i++) push(8'(8'h30 + i));
        check("pp_full", 32'(rx_full), 1);
        rx_wr_req  = 1'b1;
        rx_data_in = 8'hAA;
        rd_req     = 1'b1;
        tick();
        rx_wr_req  = 1'b0;
        rd_req     = 1'b0;
        check("pp_level", 32'(rx_level), 16);
        check("pp_ovr",   32'(ovr), 0);
        check("pp_head",  32'(rd_data), 32'h29);
        for (int i = 0; i < 15; i++) pop();
        check("pp_last",  32'(rd_data), 32'hAA);
        check("pp_lvl1",  32'(rx_level), 1);
        pop();
        check("pp_empty", 32'(rx_empty), 1);
        tick();

        // Character timeout
        push(8'h55);
        clken_ticks(639);
        check("t_before", 32'(irq_tout), 0);
        clken = 1'b1;
        tick();
        clken = 1'b0;
`ifdef UART_RX_TIMEOUT_EN
        check("t_expired", 32'(irq_tout), 1);
`else
        check("t_disabled", 32'(irq_tout), 0);
`endif
        pop();
        check("t_cleared", 32'(irq_tout), 0);
        check("t_empty",   32'(rx_empty), 1);

        // Flush with simultaneous push, then disabled receive
        for (int i = 0; i < 3; i++) push(8'(8'h60 + i));
        fifo_flush = 1'b1;
        rx_wr_req  = 1'b1;
        rx_data_in = 8'h77;
        tick();
        fifo_flush = 1'b0;
        rx_wr_req  = 1'b0;
        check("fl_level", 32'(rx_level), 0);
        check("fl_empty", 32'(rx_empty), 1);
        check("fl_tout",  32'(irq_tout), 0);
        rx_en = 1'b0;
        push(8'h88);
        rx_en = 1'b1;
        check("en_level", 32'(rx_level), 0);
        check("en_ovr",   32'(ovr), 0);

        // Asynchronous reset mid-operation
        thr = 5'd3;
        for (int i = 0; i < 5; i++) push(8'(8'h90 + i));
        tick();
`ifdef UART_RX_TIMEOUT_EN
        clken_ticks(640);
        check("ar_tout_pre", 32'(irq_tout), 1);
`endif
        check("ar_level_pre", 32'(rx_level), 5);
        check("ar_thr_pre",   32'(irq_thr), 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("ar_level", 32'(rx_level), 0);
        check("ar_empty", 32'(rx_empty), 1);
        check("ar_full",  32'(rx_full), 0);
        check("ar_data",  32'(rd_data), 0);
        check("ar_thr",   32'(irq_thr), 0);
        check("ar_tout",  32'(irq_tout), 0);
        check("ar_rts",   32'(rts_n), 0);
        check("ar_ovr",   32'(ovr), 0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
